shift_reg_univ: RTL and testbench

- Parametrised, multi-mode successor to the single-bit D flip-flop: a WIDTH-bit register with complementary outputs and an active-low enable.
- Operations: hold, parallel load, multi-bit logical/arithmetic shifts, rotates and bitwise invert, with serial fill and shifted-out bit capture.
- Serves as the general-purpose storage/shift element for datapath and serial-conversion blocks in the design.

---
 rtl/shift_reg_univ.sv | 142 ++++++++++++++
 tb/tb_shift_reg_univ.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//   WIDTH-bit multi-mode storage/shift register with complementary outputs.
//   Operations (selected by i_mode while i_enable is low):
//     000 HOLD, 001 LOAD, 010 SHL, 011 SHR (logical), 100 ASR,
//     101 ROL, 110 ROR, 111 INV.
//   Logical shifts fill with i_sin; ASR fills with the old MSB. o_sout keeps
//   the last bit pushed out by the most recent shift that actually moved bits.
//
// Ports:
//   i_clck    clock, all state changes on the rising edge
//   i_reset   synchronous active-high reset, overrides everything
//   i_enable  active-low enable (1 = hold all state)
//   i_mode    operation select
//   i_d       parallel load data
//   i_amt     shift/rotate amount
//   i_sin     serial fill bit for logical shifts
//   q         register contents
//   qbar      registered complement of q
//   o_sout    last bit shifted out
//   o_zero    combinational, high when q is all zeros
// -----------------------------------------------------------------------------
module shift_reg_univ #(
  parameter int               WIDTH       = 8,
  parameter int               AMT_W       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clck,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic [AMT_W-1:0] i_amt,
  input  logic             i_sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             o_sout,
  output logic             o_zero
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ASR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;
  localparam logic [2:0] M_INV  = 3'b111;

  int               amt_n;     // amount as an integer
  int               rot_n;     // amount reduced mod WIDTH for rotates
  logic             amt_big;   // amount >= WIDTH (non power-of-two widths only)
  logic [WIDTH-1:0] shl_v, shr_v, asr_v, rol_v, ror_v;
  logic             shl_bit, shr_bit;
  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;

  // Candidate results for every shape, built bit by bit from the current q.
  // i_amt < 2*WIDTH always holds, so one conditional subtract gives mod WIDTH.
  always_comb begin
    amt_n   = int'(i_amt);
    amt_big = (amt_n >= WIDTH);
    rot_n   = amt_big ? (amt_n - WIDTH) : amt_n;
    shl_v   = '0;
    shr_v   = '0;
    asr_v   = '0;
    rol_v   = '0;
    ror_v   = '0;
    shl_bit = 1'b0;
    shr_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      shl_v[i] = (i >= amt_n)         ? q[i - amt_n] : i_sin;
      shr_v[i] = (i + amt_n < WIDTH)  ? q[i + amt_n] : i_sin;
      asr_v[i] = (i + amt_n < WIDTH)  ? q[i + amt_n] : q[WIDTH-1];
      rol_v[i] = q[(i - rot_n + WIDTH) % WIDTH];
      ror_v[i] = q[(i + rot_n) % WIDTH];
      // Last bit leaving the MSB end (SHL) or LSB end (SHR/ASR).
      if (i == WIDTH - amt_n) shl_bit = q[i];
      if (i == amt_n - 1)     shr_bit = q[i];
    end
  end

  // Next-state selection. With i_enable high nothing below is consulted, so
  // unknown mode/data/amount inputs cannot reach q.
  always_comb begin
    q_nxt    = q;
    sout_nxt = o_sout;
    if (!i_enable) begin
      case (i_mode)
        M_HOLD: ;
        M_LOAD: q_nxt = i_d;
        M_SHL: begin
          if (amt_big) begin
            q_nxt    = {WIDTH{i_sin}};
            sout_nxt = 1'b0;
          end else if (amt_n != 0) begin
            q_nxt    = shl_v;
            sout_nxt = shl_bit;
          end
        end
        M_SHR: begin
          if (amt_big) begin
            q_nxt    = {WIDTH{i_sin}};
            sout_nxt = 1'b0;
          end else if (amt_n != 0) begin
            q_nxt    = shr_v;
            sout_nxt = shr_bit;
          end
        end
        M_ASR: begin
          if (amt_big) begin
            q_nxt    = {WIDTH{q[WIDTH-1]}};
            sout_nxt = 1'b0;
          end else if (amt_n != 0) begin
            q_nxt    = asr_v;
            sout_nxt = shr_bit;
          end
        end
        M_ROL:   q_nxt = rol_v;
        M_ROR:   q_nxt = ror_v;
        M_INV:   q_nxt = ~q;
        default: ;
      endcase
    end
  end

  // qbar is always loaded from the same source as q, so it can never drift.
  always_ff @(posedge i_clck) begin
    if (i_reset) begin
      q      <= RESET_VALUE;
      qbar   <= ~RESET_VALUE;
      o_sout <= 1'b0;
    end else begin
      q      <= q_nxt;
      qbar   <= ~q_nxt;
      o_sout <= sout_nxt;
    end
  end

  assign o_zero = (q == '0);

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

  localparam int         W  = 8;
  localparam int         AW = 3;
  localparam logic [7:0] RV = 8'hA5;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010,
                         SHR = 3'b011, ASR = 3'b100, ROL = 3'b101,
                         ROR = 3'b110, INV = 3'b111;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en_n = 1'b0;
  logic [2:0]    mode = LOAD;
  logic [W-1:0]  d = '1;
  logic [AW-1:0] amt = '0;
  logic          sin = 1'b0;

  logic [W-1:0]  q, qbar;
  logic          sout, zero;

  shift_reg_univ #(.WIDTH(W), .AMT_W(AW), .RESET_VALUE(RV)) dut (
    .i_clck(clk), .i_reset(rst), .i_enable(en_n), .i_mode(mode),
    .i_d(d), .i_amt(amt), .i_sin(sin),
    .q(q), .qbar(qbar), .o_sout(sout), .o_zero(zero)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  // Each multi-bit operation is applied as a sequence of single-bit moves.
  logic [W-1:0] q_m;
  logic         sout_m;

  always @(posedge clk) begin
    logic         msb;
    logic [W-1:0] t;
    if (rst) begin
      q_m    = RV;
      sout_m = 1'b0;
    end else if (!en_n) begin
      t   = q_m;
      msb = q_m[W-1];
      case (mode)
        LOAD: t = d;
        SHL:  for (int k = 0; k < int'(amt); k++) begin sout_m = t[W-1]; t = {t[W-2:0], sin}; end
        SHR:  for (int k = 0; k < int'(amt); k++) begin sout_m = t[0];   t = {sin, t[W-1:1]}; end
        ASR:  for (int k = 0; k < int'(amt); k++) begin sout_m = t[0];   t = {msb, t[W-1:1]}; end
        ROL:  for (int k = 0; k < int'(amt); k++) t = {t[W-2:0], t[W-1]};
        ROR:  for (int k = 0; k < int'(amt); k++) t = {t[0], t[W-1:1]};
        INV:  t = ~t;
        default: ;
      endcase
      q_m = t;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_q.push_back(q_m);
      chk("q",    q,    exp_q.pop_front());
      chk("qbar", qbar, ~q_m);
      chk("sout", {7'd0, sout}, {7'd0, sout_m});
      chk("zero", {7'd0, zero}, {7'd0, (q_m == '0)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [W-1:0] dd, input logic [AW-1:0] a, input logic s);
    @(negedge clk);
    rst = r; en_n = e; mode = m; d = dd; amt = a; sin = s;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [W-1:0] dd,
                    input logic [AW-1:0] a, input logic s);
    step(1'b0, 1'b0, m, dd, a, s);
  endtask

  // Literal check of both the DUT and the model.
  task automatic lit(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] mdl, input logic [W-1:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset dominates a pending LOAD of FF for two edges.
    step(1'b1, 1'b0, LOAD, 8'hFF, 3'd0, 1'b0);
    step(1'b1, 1'b0, LOAD, 8'hFF, 3'd0, 1'b0);
    chk_en = 1'b1;
    lit("rst_q", q, q_m, 8'hA5);
    chk("rst_qbar", qbar, 8'h5A);
    chk("rst_sout", {7'd0, sout}, 8'h00);
    chk("rst_zero", {7'd0, zero}, 8'h00);
    op(LOAD, 8'h00, 3'd0, 1'b0);
    lit("load0", q, q_m, 8'h00);
    chk("load0_zero", {7'd0, zero}, 8'h01);

    // Enable gating.
    op(LOAD, 8'h3C, 3'd0, 1'b0);
    repeat (3) step(1'b0, 1'b1, LOAD, 8'hFF, 3'd0, 1'b0);
    lit("en_hold", q, q_m, 8'h3C);
    op(LOAD, 8'hFF, 3'd0, 1'b0);
    lit("en_load", q, q_m, 8'hFF);

    // Shifts.
    op(LOAD, 8'b1001_0110, 3'd0, 1'b0);
    op(SHL, 8'h00, 3'd3, 1'b1);
    lit("shl3", q, q_m, 8'b1011_0111);
    chk("shl3_sout", {7'd0, sout}, 8'h00);
    op(SHR, 8'h00, 3'd2, 1'b0);
    lit("shr2", q, q_m, 8'b0010_1101);
    chk("shr2_sout", {7'd0, sout}, 8'h01);
    op(LOAD, 8'h80, 3'd0, 1'b0);
    op(ASR, 8'h00, 3'd1, 1'b1);
    lit("asr1", q, q_m, 8'hC0);
    chk("asr1_sout", {7'd0, sout}, 8'h00);

    // Rotates and invert; o_sout set to 1 first so "unchanged" is visible.
    op(LOAD, 8'h01, 3'd0, 1'b0);
    op(SHR, 8'h00, 3'd1, 1'b0);
    op(LOAD, 8'h81, 3'd0, 1'b0);
    op(ROL, 8'h00, 3'd1, 1'b0);
    lit("rol1", q, q_m, 8'h03);
    op(ROR, 8'h00, 3'd4, 1'b0);
    lit("ror4", q, q_m, 8'h30);
    op(INV, 8'h00, 3'd0, 1'b0);
    lit("inv", q, q_m, 8'hCF);
    chk("inv_qbar", qbar, 8'h30);
    chk("rotinv_sout", {7'd0, sout}, 8'h01);

    // Zero amount, then a chain of single-bit shifts.
    op(SHL, 8'h00, 3'd0, 1'b1);
    lit("shl0", q, q_m, 8'hCF);
    chk("shl0_sout", {7'd0, sout}, 8'h01);
    op(LOAD, 8'hFF, 3'd0, 1'b0);
    repeat (8) op(SHL, 8'h00, 3'd1, 1'b0);
    lit("chain", q, q_m, 8'h00);
    chk("chain_zero", {7'd0, zero}, 8'h01);
    chk("chain_sout", {7'd0, sout}, 8'h01);

    // Reset in the middle of a rotate stream.
    op(LOAD, 8'h01, 3'd0, 1'b0);
    repeat (3) op(ROL, 8'h00, 3'd1, 1'b0);
    step(1'b1, 1'b0, ROL, 8'h00, 3'd1, 1'b0);
    lit("midrst", q, q_m, 8'hA5);
    op(ROL, 8'h00, 3'd1, 1'b0);
    lit("midrst_rol", q, q_m, 8'h4B);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
           3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
